slave_mem_responder: RTL and testbench
======================================

Name: slave_mem_responder

Overview:
- Slave-side responder for the crossbar request/acknowledge bus; one instance sits behind each crossbar slave port.
- Accepts one req/addr/cmd/wdata transaction at a time and services it after a programmable latency from an internal word-addressed memory.
- Returns a one-cycle ack pulse, then rdata one cycle after ack, which is the ack-then-data timing the crossbar's return path expects.

Parameters:
- N, 31, MSB index of the address and data buses (bus width N+1).
- DEPTH_LOG2, 4, log2 of the memory depth in words (2^DEPTH_LOG2 words of N+1 bits).
- LATENCY, 2, edges from request acceptance to ack assertion; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid, level-sampled.
- addr  input  N+1  word address; addr[N] is the crossbar slave-select bit and is ignored here; addr[DEPTH_LOG2-1:0] indexes memory.
- cmd  input  1  1 = write, 0 = read.
- wdata  input  N+1  write data.
- ack  output  1  registered one-cycle completion pulse.
- rdata  output  N+1  registered read data, valid from the edge after ack.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wait counter=0, captured addr/cmd/wdata=0, ack=0, rdata=0, all memory words=0. Reset mid-transaction abandons it: no ack, no memory write.
- States: IDLE, WAIT, ACK, DATA. The 4-bit wait counter is sized for LATENCY<=15.
- IDLE: on an edge where req=1, capture addr, cmd and wdata, load counter=LATENCY-1, go to WAIT. Stay in IDLE if req=0.
- WAIT: the request lines are ignored. If counter==0, go to ACK, set ack<=1, and if the captured cmd=1 write the captured wdata to mem[captured addr index] at this same edge. Otherwise decrement the counter.
- ACK: next edge sets ack<=0 and goes to DATA. If the captured cmd=0, set rdata<=mem[captured addr index]; for a write, rdata holds its previous value.
- DATA: next edge goes to IDLE; req is not sampled in DATA.
- Timing, with acceptance at edge E0: ack high from E0+LATENCY to E0+LATENCY+1 (exactly one cycle). rdata is updated at E0+LATENCY+1. The next acceptance is possible at E0+LATENCY+3 at the earliest.
- req held high continuously: every IDLE edge starts a new transaction. Repeated writes are re-performed; the requester must drop req to avoid duplicates.
- Read-after-write to the same address returns the newly written data, because the write lands at the ACK-entry edge, before any later read.
- Addresses wrap modulo 2^DEPTH_LOG2. Upper address bits alias unless the optional feature is enabled.
- ack and rdata are driven only from flops; there is no combinational input-to-output path.

Optional Feature:
- Macro: SLV_RANGE_CHECK_EN.
- Defined: a transaction is out of range when captured addr[N-1:DEPTH_LOG2] is nonzero. An out-of-range write is dropped (memory unchanged) but still acked with normal timing. An out-of-range read is acked normally and returns rdata = all ones.
- Undefined: no range check is done; upper address bits are ignored (aliasing).

Test Plan:
- Assert reset mid-stream, then release -> ack=0, rdata=0, and a read of address 0x7 returns 0x00000000.
- LATENCY=2: write addr=0x3, wdata=0xA5A50001, req pulse sampled at E0 -> ack=1 only between E2 and E3; rdata unchanged (0).
- Then read addr=0x3 accepted at E0 -> ack high E2..E3, rdata=0xA5A50001 from E3 onward.
- req held high, read addr=0x5, LATENCY=2 -> ack pulses spaced exactly 5 cycles apart; rdata stable at mem[5].
- Assert reset while in WAIT after a write to addr=0x9 -> no ack pulse; a subsequent read of 0x9 returns 0x00000000.
- SLV_RANGE_CHECK_EN defined: write 0x12345678 to addr=0x10 -> acked; read addr=0x0 returns 0x00000000; read addr=0x10 returns 0xFFFFFFFF. Undefined: the same write lands in word 0x0, and reading 0x0 returns 0x12345678.

Source files
------------

// File: rtl/slave_mem_responder.sv
// Crossbar slave responder: services one req at a time from a word memory, acks after LATENCY edges, rdata one cycle later.
// Optional SLV_RANGE_CHECK_EN: out-of-range writes dropped, out-of-range reads return all ones.
module slave_mem_responder #(
    parameter int N          = 31,
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [N:0]   addr,
    input  logic         cmd,
    input  logic [N:0]   wdata,
    output logic         ack,
    output logic [N:0]   rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, DATA} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    cmd_q;
    logic                    oor_q;
    logic [N:0]              wdata_q;
    logic                    ack_q;
    logic [N:0]              rdata_q;
    logic [N:0]              mem_q [DEPTH];

    logic                    oor_d;
    logic                    unused_addr;

`ifdef SLV_RANGE_CHECK_EN
    assign oor_d = |addr[N-1:DEPTH_LOG2];
`else
    assign oor_d = 1'b0;
`endif

    // addr[N] selects the slave upstream; without range checking the rest above the index aliases.
    assign unused_addr = ^addr[N:DEPTH_LOG2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            cmd_q   <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= addr[DEPTH_LOG2-1:0];
                        cmd_q   <= cmd;
                        oor_q   <= oor_d;
                        wdata_q <= wdata;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                        // The write lands here so a following read always sees it.
                        if (cmd_q && !oor_q) begin
                            mem_q[idx_q] <= wdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= DATA;
                    if (!cmd_q) begin
                        rdata_q <= oor_q ? '1 : mem_q[idx_q];
                    end
                end
                DATA: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Bench for slave_mem_responder: table-driven transactions with an rdata scoreboard plus hand sequences for reset, streaming and range check.
module tb_slave_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] a;
        logic        c;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    slave_mem_responder #(.N(31), .DEPTH_LOG2(4), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .addr  (addr),
        .cmd   (cmd),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One req pulse, then check ack lands exactly LAT edges later for one cycle and rdata follows.
    task automatic run_txn(input vec_t v, input string name);
        int k;
        logic [31:0] e;
        @(negedge clk);
        req = 1'b1; addr = v.a; cmd = v.c; wdata = v.wd;
        exp_q.push_back(v.exp_rd);
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (ack !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, " ack latency"}, 32'(k), 32'(LAT));
        @(negedge clk);
        check({name, " ack width"}, {31'd0, ack}, 32'd0);
        e = exp_q.pop_front();
        check({name, " rdata"}, rdata, e);
        @(negedge clk);
    endtask

    initial begin
        int ack_cycles [$];
        int seen;
        logic prev_ack;
        vec_t v;

        vecs[0]  = '{32'h0000_0003, 1'b1, 32'hA5A5_0001, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0003, 1'b0, 32'h0,         32'hA5A5_0001};
        vecs[2]  = '{32'h0000_0007, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0001};
        vecs[3]  = '{32'h0000_0007, 1'b0, 32'h0,         32'hDEAD_BEEF};
        vecs[4]  = '{32'h0000_000F, 1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF};
        vecs[5]  = '{32'h0000_000F, 1'b0, 32'h0,         32'h0000_FFFF};
        vecs[6]  = '{32'h0000_0000, 1'b0, 32'h0,         32'h0000_0000};
        vecs[7]  = '{32'h0000_0000, 1'b1, 32'h0000_0001, 32'h0000_0000};
        vecs[8]  = '{32'h0000_0000, 1'b0, 32'h0,         32'h0000_0001};
        vecs[9]  = '{32'h8000_0005, 1'b1, 32'h0000_0055, 32'h0000_0001};
        vecs[10] = '{32'h0000_0005, 1'b0, 32'h0,         32'h0000_0055};

        reset = 1'b1; req = 1'b0; addr = '0; cmd = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Streaming: req held high reading word 5.
        @(negedge clk);
        req = 1'b1; addr = 32'h5; cmd = 1'b0;
        prev_ack = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ack === 1'b1 && prev_ack !== 1'b1) ack_cycles.push_back(cyc);
            if (ack === 1'b0 && prev_ack === 1'b1) check("stream rdata", rdata, 32'h0000_0055);
            prev_ack = ack;
        end
        req = 1'b0;
        repeat (8) @(negedge clk);
        check("stream pulse count", 32'(ack_cycles.size()), 32'd4);
        for (int i = 1; i < ack_cycles.size(); i++) begin
            check("stream spacing", 32'(ack_cycles[i] - ack_cycles[i-1]), 32'(LAT + 3));
        end

        // Reset while waiting on a write to 0x9 must abandon it.
        @(negedge clk);
        req = 1'b1; addr = 32'h9; cmd = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (ack === 1'b1) seen++;
        end
        check("midreset no ack", 32'(seen), 32'd0);
        check("midreset rdata", rdata, 32'd0);
        v = '{32'h0000_0009, 1'b0, 32'h0, 32'h0000_0000};
        run_txn(v, "read9 after reset");
        v = '{32'h0000_0007, 1'b0, 32'h0, 32'h0000_0000};
        run_txn(v, "read7 after reset");

        // Upper address bits: dropped/all-ones with range check, aliasing without.
        v = '{32'h0000_0010, 1'b1, 32'h1234_5678, 32'h0000_0000};
        run_txn(v, "write 0x10");
`ifdef SLV_RANGE_CHECK_EN
        v = '{32'h0000_0000, 1'b0, 32'h0, 32'h0000_0000};
        run_txn(v, "read 0x0 after 0x10");
        v = '{32'h0000_0010, 1'b0, 32'h0, 32'hFFFF_FFFF};
        run_txn(v, "read 0x10");
`else
        v = '{32'h0000_0000, 1'b0, 32'h0, 32'h1234_5678};
        run_txn(v, "read 0x0 after 0x10");
        v = '{32'h0000_0010, 1'b0, 32'h0, 32'h1234_5678};
        run_txn(v, "read 0x10");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
